pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central hazard, forwarding and flush controller for the 5-stage core (IF/ID/EX/MEM/WB).
//  Tracks a shadow of each in-flight instruction's destination and decides forwarding selects,
//  load-use stalls, taken-branch squashes and data-memory wait freezes, then drives every stage enable.
//  Replaces the ad-hoc HA/HB/WHA/WHB and flush_ID logic of the 4-stage core.
// PARAMETERS
//  RA_W        5   register address width (2**RA_W regs; address 0 is hard-wired zero, never forwarded)
//  BR_PENALTY  2   younger instructions squashed on a taken branch resolved in EX; legal 1..3
//  CNT_W       2   width of the squash counter; must hold BR_PENALTY
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     synchronous reset, active-low
//  id_valid      in   1     ID holds a real (non-bubble) instruction
//  id_aa, id_ba  in   RA_W  ID source register addresses
//  id_use_a/b    in   1     ID actually reads A/B (0 when PC or immediate is muxed in)
//  id_rw         in   1     ID instruction writes the register file
//  id_da         in   RA_W  ID destination address
//  id_load       in   1     ID instruction is a load (result available only after MEM)
//  id_mem        in   1     ID instruction accesses data memory (load or store)
//  ex_br_taken   in   1     instruction in EX resolved as taken branch/jump this cycle
//  dm_ack        in   1     data memory completes the MEM-stage access this cycle
//  fwd_a/b_sel   out  2     0 regfile, 1 EX result, 2 MEM result, 3 WB bus
//  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out 1 each  stage-register enables
//  if_id_kill    out  1     load a bubble into IF/ID
//  id_ex_kill    out  1     load a bubble into ID/EX
//  dm_req        out  1     MEM stage holds a valid memory access
//  stall_cnt     out  16    saturating count of stall cycles since reset (perf)
// BEHAVIOUR
//  State: shadow regs ex_*, mem_*, wb_* = {valid, rw, da, load, mem}, advanced with the stage enables;
//   squash counter kill_cnt (CNT_W bits); stall_cnt.
//  Reset (rst_n=0 at edge): all shadow valid=0, kill_cnt=0, stall_cnt=0. Combinational outputs while
//   rst_n=0: all enables 0, both kills 1, fwd sels 0, dm_req 0.
//  Forwarding, per operand X in {A,B}: hit_S = S.valid & S.rw & (S.da!=0) & id_use_x & (S.da==id_xa).
//   Priority EX(1) > MEM(2) > WB(3) > regfile(0). An EX hit where ex.load=1 is not forwardable.
//  Load-use: lu = id_valid & (EX hit on A or B) & ex.load -> pc_en=if_id_en=0, id_ex_kill=1,
//   remaining enables 1. Exactly one bubble; next cycle forwarding comes from MEM (sel 2).
//  Mem wait: dm_req = mem.valid & mem.mem. dm_req & !dm_ack -> freeze: ALL enables 0, kills 0,
//   shadow and kill_cnt hold. Freeze has top priority over branch and load-use.
//  Branch: ex_br_taken & ex.valid & !freeze -> if_id_kill=1, id_ex_kill=1, pc_en=1 (PC takes target),
//   kill_cnt <= BR_PENALTY-2 (floored at 0). While kill_cnt!=0 and not frozen: if_id_kill=1, kill_cnt-1.
//   ex_br_taken with ex.valid=0 (squashed instruction) is ignored: no back-to-back branch squash.
//  Branch vs load-use same cycle: branch wins; the stalled ID instruction is wrong path and is killed.
//  Shadow advance (when each enable=1): ex<=id fields & id_valid & !id_ex_kill; mem<=ex; wb<=mem.
//   On mem_wb_en=0 during freeze, wb holds (WB forwarding remains valid).
//  stall_cnt +1 on every freeze or load-use cycle; saturates at 16'hFFFF.
//  Zero-latency control: all outputs combinational from current shadow state + inputs.
// STRUCTURE
//  pipe_pkg: FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings, shadow-entry struct/field widths.
//  One sub-module pipe_fwd_cmp (one shadow entry vs one source -> hit, hit_load), instantiated 6x.
// TESTING
//  add r3 in EX, ID reads r3 as A -> fwd_a_sel=1, no stall; same with r0 as dest -> fwd_a_sel=0.
//  r3 written by EX, MEM and WB simultaneously, ID reads r3 as B -> fwd_b_sel=1 (youngest wins).
//  lw r5 in EX, ID uses r5 -> one cycle pc_en=if_id_en=0, id_ex_kill=1; next cycle fwd sel=2.
//  Taken branch, BR_PENALTY=3 -> cycle0 both kills; cycle1 if_id_kill=1; cycle2 no kills.
//  dm_req with dm_ack low 3 cycles and ex_br_taken=1 -> all enables 0 for 3 cycles, branch acted
//   on in cycle 4; stall_cnt=3.
//  rst_n low mid-load-use stall -> next cycle all shadows invalid, fwd sels 0, stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and shadow-entry layout for the 5-stage pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Per-stage shadow flags; destination address and memory flag are held alongside.
  typedef struct packed {
    logic valid;
    logic rw;
    logic load;
  } sh_flags_t;

  localparam int STALL_W = 16;
  localparam int NUM_SH  = 3;

  // Lower index is the younger stage; the youngest forwardable writer wins.
  function automatic fwd_sel_e pickFwd(input logic [NUM_SH-1:0] ok);
    if (ok[0])      return FWD_EX;
    else if (ok[1]) return FWD_MEM;
    else if (ok[2]) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_fwd_cmp.sv
// Compares one in-flight shadow entry against one ID source operand.
module pipe_fwd_cmp #(
  parameter int RA_W = 5
) (
  input  logic            i_valid,
  input  logic            i_rw,
  input  logic            i_load,
  input  logic [RA_W-1:0] i_da,
  input  logic [RA_W-1:0] i_src,
  input  logic            i_use,
  output logic            o_hit,
  output logic            o_hit_load
);

  // Register 0 is hard-wired zero, so a write to it is never a producer.
  assign o_hit      = i_valid & i_rw & (i_da != '0) & i_use & (i_da == i_src);
  assign o_hit_load = o_hit & i_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller: shadows EX/MEM/WB destinations and drives stage enables.
module pipe_hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_id_valid,
  input  logic [RA_W-1:0] i_id_aa,
  input  logic [RA_W-1:0] i_id_ba,
  input  logic            i_id_use_a,
  input  logic            i_id_use_b,
  input  logic            i_id_rw,
  input  logic [RA_W-1:0] i_id_da,
  input  logic            i_id_load,
  input  logic            i_id_mem,
  input  logic            i_ex_br_taken,
  input  logic            i_dm_ack,
  output logic [1:0]      o_fwd_a_sel,
  output logic [1:0]      o_fwd_b_sel,
  output logic            o_pc_en,
  output logic            o_if_id_en,
  output logic            o_id_ex_en,
  output logic            o_ex_mem_en,
  output logic            o_mem_wb_en,
  output logic            o_if_id_kill,
  output logic            o_id_ex_kill,
  output logic            o_dm_req,
  output logic [15:0]     o_stall_cnt
);
  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] KILL_INIT = CNT_W'((BR_PENALTY > 2) ? BR_PENALTY - 2 : 0);
  // Only an EX-stage load has no result yet; loads further down forward normally.
  localparam logic [NUM_SH-1:0] NOFWD_LOAD = 3'b001;

  sh_flags_t              r_ex, r_mem, r_wb;
  logic [RA_W-1:0]        r_exDa, r_memDa, r_wbDa;
  logic                   r_exMem, r_memMem;
  logic [CNT_W-1:0]       r_killCnt;
  logic [STALL_W-1:0]     r_stallCnt;

  logic [NUM_SH-1:0]      w_shValid, w_shRw, w_shLoad;
  logic [RA_W-1:0]        w_shDa [NUM_SH];
  logic [NUM_SH-1:0]      w_hitA, w_hitB, w_hitLoadA, w_hitLoadB;
  logic [NUM_SH-1:0]      w_fwdOkA, w_fwdOkB;
  logic                   w_dmReq, w_freeze, w_br, w_lu;

  assign w_shValid = {r_wb.valid, r_mem.valid, r_ex.valid};
  assign w_shRw    = {r_wb.rw,    r_mem.rw,    r_ex.rw};
  assign w_shLoad  = {r_wb.load,  r_mem.load,  r_ex.load};
  assign w_shDa[0] = r_exDa;
  assign w_shDa[1] = r_memDa;
  assign w_shDa[2] = r_wbDa;

  for (genvar g = 0; g < NUM_SH; g++) begin : g_cmp
    pipe_fwd_cmp #(.RA_W(RA_W)) u_cmpA (
      .i_valid(w_shValid[g]), .i_rw(w_shRw[g]), .i_load(w_shLoad[g]), .i_da(w_shDa[g]),
      .i_src(i_id_aa), .i_use(i_id_use_a), .o_hit(w_hitA[g]), .o_hit_load(w_hitLoadA[g])
    );
    pipe_fwd_cmp #(.RA_W(RA_W)) u_cmpB (
      .i_valid(w_shValid[g]), .i_rw(w_shRw[g]), .i_load(w_shLoad[g]), .i_da(w_shDa[g]),
      .i_src(i_id_ba), .i_use(i_id_use_b), .o_hit(w_hitB[g]), .o_hit_load(w_hitLoadB[g])
    );
  end

  assign w_fwdOkA = w_hitA & ~(w_hitLoadA & NOFWD_LOAD);
  assign w_fwdOkB = w_hitB & ~(w_hitLoadB & NOFWD_LOAD);

  // Freeze outranks a branch, and a branch outranks load-use (the stalled ID op is wrong-path).
  assign w_dmReq  = r_mem.valid & r_memMem;
  assign w_freeze = w_dmReq & ~i_dm_ack;
  assign w_br     = i_ex_br_taken & r_ex.valid & ~w_freeze;
  assign w_lu     = i_id_valid & (|((w_hitLoadA | w_hitLoadB) & NOFWD_LOAD)) & ~w_freeze & ~w_br;

  always_comb begin
    o_pc_en      = 1'b0;
    o_if_id_en   = 1'b0;
    o_id_ex_en   = 1'b0;
    o_ex_mem_en  = 1'b0;
    o_mem_wb_en  = 1'b0;
    o_if_id_kill = 1'b1;
    o_id_ex_kill = 1'b1;
    o_dm_req     = 1'b0;
    o_fwd_a_sel  = FWD_RF;
    o_fwd_b_sel  = FWD_RF;
    if (rst_n) begin
      o_dm_req     = w_dmReq;
      o_fwd_a_sel  = pickFwd(w_fwdOkA);
      o_fwd_b_sel  = pickFwd(w_fwdOkB);
      o_if_id_kill = 1'b0;
      o_id_ex_kill = 1'b0;
      if (!w_freeze) begin
        o_pc_en      = ~w_lu;
        o_if_id_en   = ~w_lu;
        o_id_ex_en   = 1'b1;
        o_ex_mem_en  = 1'b1;
        o_mem_wb_en  = 1'b1;
        o_if_id_kill = w_br | (r_killCnt != '0);
        o_id_ex_kill = w_br | w_lu;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex       <= '0;
      r_mem      <= '0;
      r_wb       <= '0;
      r_exDa     <= '0;
      r_memDa    <= '0;
      r_wbDa     <= '0;
      r_exMem    <= 1'b0;
      r_memMem   <= 1'b0;
      r_killCnt  <= '0;
      r_stallCnt <= '0;
    end else begin
      if (o_id_ex_en) begin
        r_ex.valid <= i_id_valid & ~o_id_ex_kill;
        r_ex.rw    <= i_id_rw;
        r_ex.load  <= i_id_load;
        r_exDa     <= i_id_da;
        r_exMem    <= i_id_mem;
      end
      if (o_ex_mem_en) begin
        r_mem    <= r_ex;
        r_memDa  <= r_exDa;
        r_memMem <= r_exMem;
      end
      if (o_mem_wb_en) begin
        r_wb   <= r_mem;
        r_wbDa <= r_memDa;
      end
      if (!w_freeze) begin
        if (w_br)                   r_killCnt <= KILL_INIT;
        else if (r_killCnt != '0)   r_killCnt <= r_killCnt - 1'b1;
      end
      if ((w_freeze | w_lu) && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a pipeline-queue model.
module tb_pipe_hazard_ctrl;

  localparam int BRP = 3;

  logic        clk = 1'b0;
  logic        rstN;
  logic        idValid, idUseA, idUseB, idRw, idLoad, idMem, exBrTaken, dmAck;
  logic [4:0]  idAa, idBa, idDa;
  logic [1:0]  fwdASel, fwdBSel;
  logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdKill, idExKill, dmReq;
  logic [15:0] stallCnt;

  wire [7:0] ctrlVec = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdKill, idExKill, dmReq};

  int nCmp = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(5), .BR_PENALTY(BRP), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rstN),
    .i_id_valid(idValid), .i_id_aa(idAa), .i_id_ba(idBa),
    .i_id_use_a(idUseA), .i_id_use_b(idUseB), .i_id_rw(idRw), .i_id_da(idDa),
    .i_id_load(idLoad), .i_id_mem(idMem), .i_ex_br_taken(exBrTaken), .i_dm_ack(dmAck),
    .o_fwd_a_sel(fwdASel), .o_fwd_b_sel(fwdBSel),
    .o_pc_en(pcEn), .o_if_id_en(ifIdEn), .o_id_ex_en(idExEn), .o_ex_mem_en(exMemEn),
    .o_mem_wb_en(memWbEn), .o_if_id_kill(ifIdKill), .o_id_ex_kill(idExKill),
    .o_dm_req(dmReq), .o_stall_cnt(stallCnt)
  );

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit       v;
    bit       rw;
    bit       ld;
    bit       mm;
    bit [4:0] da;
  } entry_t;

  entry_t pipeM [3];
  int     killM;
  int     stallM;
  bit     mFreeze, mBr, mLu;
  bit [1:0]  eFwdA, eFwdB;
  bit [7:0]  eCtrl;
  bit [15:0] eStall;

  function automatic bit [1:0] modelFwd(bit [4:0] src, bit rd);
    for (int s = 0; s < 3; s++) begin
      if (pipeM[s].v && pipeM[s].rw && pipeM[s].da != 0 && rd && pipeM[s].da == src) begin
        if (s == 0 && pipeM[s].ld) continue;
        return 2'(s + 1);
      end
    end
    return 2'd0;
  endfunction

  task automatic modelEval();
    bit exLoadHit, dm, pc, ifk, idk;
    eStall = 16'(stallM);
    if (!rstN) begin
      mFreeze = 0; mBr = 0; mLu = 0;
      eFwdA = 0; eFwdB = 0;
      eCtrl = 8'b00000_11_0;
    end else begin
      dm = pipeM[0].v === 1'bx ? 0 : (pipeM[1].v && pipeM[1].mm);
      mFreeze = dm && !dmAck;
      mBr = exBrTaken && pipeM[0].v && !mFreeze;
      exLoadHit = pipeM[0].v && pipeM[0].rw && pipeM[0].ld && pipeM[0].da != 0 &&
                  ((idUseA && idAa == pipeM[0].da) || (idUseB && idBa == pipeM[0].da));
      mLu = idValid && exLoadHit && !mFreeze && !mBr;
      eFwdA = modelFwd(idAa, idUseA);
      eFwdB = modelFwd(idBa, idUseB);
      if (mFreeze) begin
        eCtrl = {5'b00000, 2'b00, dm};
      end else begin
        pc  = !mLu;
        ifk = mBr || killM > 0;
        idk = mBr || mLu;
        eCtrl = {pc, pc, 3'b111, ifk, idk, dm};
      end
    end
  endtask

  task automatic modelAdvance();
    if (!rstN) begin
      foreach (pipeM[i]) pipeM[i] = '{0, 0, 0, 0, 5'd0};
      killM = 0;
      stallM = 0;
    end else begin
      if (!mFreeze) begin
        pipeM[2] = pipeM[1];
        pipeM[1] = pipeM[0];
        pipeM[0] = '{idValid && !eCtrl[1], idRw, idLoad, idMem, idDa};
        killM = mBr ? BRP - 2 : (killM > 0 ? killM - 1 : 0);
      end
      if ((mFreeze || mLu) && stallM < 65535) stallM++;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    modelEval();
  endtask

  task automatic advance();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic setIdle();
    idValid = 0; idAa = 0; idBa = 0; idUseA = 0; idUseB = 0;
    idRw = 0; idDa = 0; idLoad = 0; idMem = 0; exBrTaken = 0; dmAck = 1;
  endtask

  task automatic setId(bit v, bit [4:0] aa, bit [4:0] ba, bit ua, bit ub, bit rw, bit [4:0] da,
                       bit ld, bit mm);
    idValid = v; idAa = aa; idBa = ba; idUseA = ua; idUseB = ub;
    idRw = rw; idDa = da; idLoad = ld; idMem = mm;
  endtask

  task automatic doReset();
    setIdle();
    rstN = 0;
    settle();
    advance();
    rstN = 1;
  endtask

  task automatic test_reset();
    setIdle();
    rstN = 0;
    settle();
    nCmp++; if (ctrlVec !== 8'b00000_11_0) begin nMis++; $display("[TB] FAIL reset_ctrl: got %b want %b", ctrlVec, 8'b00000_11_0); end
    nCmp++; if (fwdASel !== 2'd0) begin nMis++; $display("[TB] FAIL reset_fwd_a: got %0d want 0", fwdASel); end
    advance();
    rstN = 1;
    setId(1, 5'd3, 5'd3, 1, 1, 0, 5'd0, 0, 0);
    settle();
    nCmp++; if (stallCnt !== 16'd0) begin nMis++; $display("[TB] FAIL reset_stall: got %0d want 0", stallCnt); end
    nCmp++; if (ctrlVec !== 8'b11111_00_0) begin nMis++; $display("[TB] FAIL reset_run_ctrl: got %b want %b", ctrlVec, 8'b11111_00_0); end
    advance();
  endtask

  task automatic test_forwarding();
    doReset();
    setId(1, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    settle(); advance();
    setId(1, 5'd3, 0, 1, 0, 1, 5'd3, 0, 0);
    settle();
    nCmp++; if (fwdASel !== 2'd1) begin nMis++; $display("[TB] FAIL fwd_ex: got %0d want 1", fwdASel); end
    nCmp++; if ({pcEn, idExKill} !== 2'b10) begin nMis++; $display("[TB] FAIL fwd_ex_nostall: got %b want 10", {pcEn, idExKill}); end
    advance();
    setId(1, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    settle(); advance();
    setId(1, 0, 5'd3, 0, 1, 0, 5'd0, 0, 0);
    settle();
    nCmp++; if (fwdBSel !== 2'd1) begin nMis++; $display("[TB] FAIL fwd_youngest: got %0d want 1", fwdBSel); end
    advance();
    setId(0, 0, 5'd3, 0, 1, 0, 5'd0, 0, 0);
    settle();
    nCmp++; if (fwdBSel !== 2'd2) begin nMis++; $display("[TB] FAIL fwd_mem: got %0d want 2", fwdBSel); end
    advance();
    settle(); advance();
    settle();
    nCmp++; if (fwdBSel !== 2'd0) begin nMis++; $display("[TB] FAIL fwd_drained: got %0d want 0", fwdBSel); end
    advance();
    doReset();
    setId(1, 0, 0, 0, 0, 1, 5'd0, 0, 0);
    settle(); advance();
    setId(1, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0);
    settle();
    nCmp++; if (fwdASel !== 2'd0) begin nMis++; $display("[TB] FAIL fwd_r0: got %0d want 0", fwdASel); end
    advance();
  endtask

  task automatic test_load_use();
    doReset();
    setId(1, 0, 0, 0, 0, 1, 5'd5, 1, 1);
    settle(); advance();
    setId(1, 5'd5, 0, 1, 0, 1, 5'd6, 0, 0);
    settle();
    nCmp++; if (ctrlVec !== 8'b00111_01_0) begin nMis++; $display("[TB] FAIL lu_stall: got %b want %b", ctrlVec, 8'b00111_01_0); end
    nCmp++; if (fwdASel !== 2'd0) begin nMis++; $display("[TB] FAIL lu_nofwd: got %0d want 0", fwdASel); end
    advance();
    settle();
    nCmp++; if (fwdASel !== 2'd2) begin nMis++; $display("[TB] FAIL lu_fwd_mem: got %0d want 2", fwdASel); end
    nCmp++; if (ctrlVec !== 8'b11111_00_1) begin nMis++; $display("[TB] FAIL lu_release: got %b want %b", ctrlVec, 8'b11111_00_1); end
    nCmp++; if (stallCnt !== 16'd1) begin nMis++; $display("[TB] FAIL lu_stall_cnt: got %0d want 1", stallCnt); end
    advance();
  endtask

  task automatic test_branch();
    doReset();
    setId(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    settle(); advance();
    exBrTaken = 1;
    setId(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0, 0);
    settle();
    nCmp++; if ({pcEn, ifIdKill, idExKill} !== 3'b111) begin nMis++; $display("[TB] FAIL br_c0: got %b want 111", {pcEn, ifIdKill, idExKill}); end
    advance();
    settle();
    nCmp++; if ({ifIdKill, idExKill} !== 2'b10) begin nMis++; $display("[TB] FAIL br_c1: got %b want 10", {ifIdKill, idExKill}); end
    advance();
    exBrTaken = 0;
    settle();
    nCmp++; if ({ifIdKill, idExKill} !== 2'b00) begin nMis++; $display("[TB] FAIL br_c2: got %b want 00", {ifIdKill, idExKill}); end
    advance();
  endtask

  task automatic test_mem_wait();
    doReset();
    setId(1, 0, 0, 0, 0, 0, 5'd0, 0, 1);
    settle(); advance();
    setId(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    settle(); advance();
    exBrTaken = 1;
    dmAck = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      nCmp++; if (ctrlVec !== 8'b00000_00_1) begin nMis++; $display("[TB] FAIL freeze_c%0d: got %b want %b", c, ctrlVec, 8'b00000_00_1); end
      advance();
    end
    dmAck = 1;
    settle();
    nCmp++; if ({pcEn, ifIdKill, idExKill} !== 3'b111) begin nMis++; $display("[TB] FAIL freeze_br: got %b want 111", {pcEn, ifIdKill, idExKill}); end
    nCmp++; if (stallCnt !== 16'd3) begin nMis++; $display("[TB] FAIL freeze_stall_cnt: got %0d want 3", stallCnt); end
    advance();
    exBrTaken = 0;
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    setId(1, 0, 0, 0, 0, 1, 5'd5, 1, 0);
    settle(); advance();
    setId(1, 5'd5, 0, 1, 0, 0, 5'd0, 0, 0);
    settle();
    nCmp++; if (pcEn !== 1'b0) begin nMis++; $display("[TB] FAIL rst_mid_pre: got %b want 0", pcEn); end
    rstN = 0;
    #1;
    modelEval();
    nCmp++; if (ctrlVec !== 8'b00000_11_0) begin nMis++; $display("[TB] FAIL rst_mid_ctrl: got %b want %b", ctrlVec, 8'b00000_11_0); end
    advance();
    rstN = 1;
    settle();
    nCmp++; if ({fwdASel, pcEn} !== 3'b001) begin nMis++; $display("[TB] FAIL rst_mid_after: got %b want 001", {fwdASel, pcEn}); end
    nCmp++; if (stallCnt !== 16'd0) begin nMis++; $display("[TB] FAIL rst_mid_stall_cnt: got %0d want 0", stallCnt); end
    advance();
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 800; c++) begin
      rstN      = ($urandom_range(0, 99) != 0);
      idValid   = ($urandom_range(0, 9) < 8);
      idAa      = 5'($urandom_range(0, 3));
      idBa      = 5'($urandom_range(0, 3));
      idUseA    = $urandom_range(0, 1);
      idUseB    = $urandom_range(0, 1);
      idRw      = ($urandom_range(0, 9) < 7);
      idDa      = 5'($urandom_range(0, 3));
      idLoad    = ($urandom_range(0, 9) < 3);
      idMem     = idLoad | ($urandom_range(0, 9) < 2);
      exBrTaken = ($urandom_range(0, 9) < 2);
      dmAck     = ($urandom_range(0, 9) < 7);
      settle();
      nCmp++; if (ctrlVec !== eCtrl) begin nMis++; $display("[TB] FAIL rnd_ctrl cyc %0d: got %b want %b", c, ctrlVec, eCtrl); end
      nCmp++; if (fwdASel !== eFwdA) begin nMis++; $display("[TB] FAIL rnd_fwd_a cyc %0d: got %0d want %0d", c, fwdASel, eFwdA); end
      nCmp++; if (fwdBSel !== eFwdB) begin nMis++; $display("[TB] FAIL rnd_fwd_b cyc %0d: got %0d want %0d", c, fwdBSel, eFwdB); end
      nCmp++; if (stallCnt !== eStall) begin nMis++; $display("[TB] FAIL rnd_stall cyc %0d: got %0d want %0d", c, stallCnt, eStall); end
      advance();
    end
    rstN = 1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    setIdle();
    rstN = 0;
    foreach (pipeM[i]) pipeM[i] = '{0, 0, 0, 0, 5'd0};
    killM = 0;
    stallM = 0;
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
